// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester data-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 8;
  localparam int MEM_DEPTH_DEF = 256;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin chooser: a lone request always wins, a tie goes to ptr.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt_valid,
  output logic gnt_id
);

  // Winner selection
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = REQ_CPU;
    if (req0 && req1) begin
      gnt_id = ptr;
    end else if (req1) begin
      gnt_id = REQ_LDR;
    end else begin
      gnt_id = REQ_CPU;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port data memory between the CPU path and the loader,
// one IDLE -> ACCESS -> RESP transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);

  state_e              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                id_q, id_d;
  logic                we_q, we_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                gnt_valid;
  logic                gnt_id;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_oob;

  rr_pick2 u_pick (
    .req0      (req0),
    .req1      (req1),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Route the winning requester's command; range check uses the full address
  always_comb begin
    if (gnt_id == REQ_LDR) begin
      sel_we    = we1;
      sel_addr  = addr1;
      sel_wdata = wdata1;
    end else begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
    end
    sel_oob = ({1'b0, sel_addr} >= DEPTH_X);
  end

  // Next-state and holding-register updates
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ACCESS;
          id_d    = gnt_id;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          err_d   = sel_oob;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (!we_q && !err_q) begin
          rdata_d = mem_rdata;
        end else begin
          rdata_d = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = ~id_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode; the write strobe is gated by rst so an aborted write never commits
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err       = 1'b0;
    rdata     = '0;
    busy      = (state_q != IDLE);
    case (state_q)
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_read  = !we_q && !err_q;
        mem_write = we_q && !err_q && !rst;
      end
      RESP: begin
        ack0  = (id_q == REQ_CPU);
        ack1  = (id_q == REQ_LDR);
        err   = err_q;
        rdata = rdata_q;
      end
      default: begin
        mem_read = 1'b0;
      end
    endcase
  end

  // State and holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= REQ_CPU;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural 256x8 memory attached.
module tb_mem_arbiter;

  typedef struct {
    logic       id;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = 16'h0000, addr1 = 16'h0000;
  logic [7:0]  wdata0 = 8'h00, wdata1 = 8'h00;
  logic        ack0, ack1, err, busy, mem_read, mem_write;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  logic [7:0]  env_mem [256];
  logic [7:0]  ref_mem [256];
  logic        mem_init = 1'b1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          wr_seen = 0;
  bit          chk_gap = 1'b0;
  bit          have_prev = 1'b0;
  int          prev_ack_cyc = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .err(err), .busy(busy),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = env_mem[mem_addr[7:0]];

  // Memory preloaded with addr ^ 0x1F, so word 16 holds 0x0F
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i) ^ 8'h1F;
    end else if (mem_write) begin
      env_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic drive(input logic id, input logic r, input logic we, input logic [15:0] a,
                       input logic [7:0] d);
    if (id) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
    else begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  task automatic wait_ack(input logic id);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if ((id ? ack1 : ack0) === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) check_eq("ack_timeout", 32'd0, 32'd1);
  endtask

  function automatic exp_t predict(input logic id, input logic we, input logic [15:0] a,
                                   input logic [7:0] d);
    exp_t e;
    e.id    = id;
    e.err   = (a >= 16'd256);
    e.rdata = (we || e.err) ? 8'h00 : ref_mem[a[7:0]];
    if (we && !e.err) ref_mem[a[7:0]] = d;
    return e;
  endfunction

  task automatic access(input logic id, input logic we, input logic [15:0] a, input logic [7:0] d);
    int  c0;
    logic oob;
    oob = (a >= 16'd256);
    exp_q.push_back(predict(id, we, a, d));
    @(negedge clk);
    drive(id, 1'b1, we, a, d);
    c0 = cyc;
    @(negedge clk);
    check_eq("acc_busy", 32'(busy), 32'd1);
    check_eq("acc_mem_read", 32'(mem_read), 32'(!we && !oob));
    check_eq("acc_mem_write", 32'(mem_write), 32'(we && !oob));
    check_eq("acc_mem_addr", 32'(mem_addr), 32'(a));
    check_eq("acc_mem_wdata", 32'(mem_wdata), 32'(d));
    wait_ack(id);
    check_eq("latency", 32'(cyc - c0), 32'd2);
    drive(id, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    check_eq("post_busy", 32'(busy), 32'd0);
    check_eq("post_mem_read", 32'(mem_read), 32'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_acks", 32'({ack0, ack1}), 32'd0);
    check_eq("rst_mem_ctl", 32'({mem_read, mem_write}), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_rdata_err", 32'({rdata, err}), 32'd0);
  endtask

  // Scoreboard monitor: every ack is matched against the oldest expectation
  initial begin
    forever begin
      @(negedge clk);
      if (mem_write === 1'b1) wr_seen++;
      if (!chk_gap) have_prev = 1'b0;
      if (ack0 === 1'b1 || ack1 === 1'b1) begin
        check_eq("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_ack", 32'({ack1, ack0}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("ack_id", 32'(ack1), 32'(mon_e.id));
          check_eq("ack_rdata", 32'(rdata), 32'(mon_e.rdata));
          check_eq("ack_err", 32'(err), 32'(mon_e.err));
        end
        if (chk_gap && have_prev) check_eq("ack_gap", 32'(cyc - prev_ack_cyc), 32'd3);
        prev_ack_cyc = cyc;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h1F;
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    reset_dut();

    access(1'b0, 1'b0, 16'h0010, 8'h00);
    access(1'b1, 1'b1, 16'h0020, 8'hA5);
    access(1'b1, 1'b0, 16'h0020, 8'h00);
    access(1'b1, 1'b1, 16'h00FF, 8'h3C);
    access(1'b0, 1'b0, 16'h00FF, 8'h00);

    w0 = wr_seen;
    access(1'b0, 1'b1, 16'h0100, 8'h77);
    check_eq("oob_no_write", 32'(wr_seen - w0), 32'd0);
    access(1'b1, 1'b0, 16'hFFFF, 8'h00);
    access(1'b0, 1'b0, 16'h0000, 8'h00);

    // Write aborted by reset during ACCESS: no commit, no ack
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0005, 8'h55);
    @(negedge clk);
    check_eq("abort_in_access", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("abort_wr_gated", 32'(mem_write), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_ack0", 32'(ack0), 32'd0);
    repeat (3) @(negedge clk);
    access(1'b0, 1'b0, 16'h0005, 8'h00);

    // Request held one cycle past ack is served again
    begin
      int c1;
      exp_q.push_back(predict(1'b0, 1'b0, 16'h0033, 8'h00));
      exp_q.push_back(predict(1'b0, 1'b0, 16'h0033, 8'h00));
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 16'h0033, 8'h00);
      @(negedge clk);
      wait_ack(1'b0);
      c1 = cyc;
      @(negedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      wait_ack(1'b0);
      check_eq("held_gap", 32'(cyc - c1), 32'd3);
      repeat (2) @(negedge clk);
    end

    // Continuous contention after reset: grants alternate 0,1,0,1
    reset_dut();
    chk_gap = 1'b1;
    exp_q.push_back(predict(1'b0, 1'b0, 16'h0040, 8'h00));
    exp_q.push_back(predict(1'b1, 1'b0, 16'h0041, 8'h00));
    exp_q.push_back(predict(1'b0, 1'b0, 16'h0042, 8'h00));
    exp_q.push_back(predict(1'b1, 1'b0, 16'h0043, 8'h00));
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          bit got0 = 1'b0;
          drive(1'b0, 1'b1, 1'b0, 16'h0040 + 16'(2 * k), 8'h00);
          for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack0 === 1'b1) begin got0 = 1'b1; break; end
          end
          if (!got0) check_eq("cont_ack0_timeout", 32'd0, 32'd1);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          bit got1 = 1'b0;
          drive(1'b1, 1'b1, 1'b0, 16'h0041 + 16'(2 * k), 8'h00);
          for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ack1 === 1'b1) begin got1 = 1'b1; break; end
          end
          if (!got1) check_eq("cont_ack1_timeout", 32'd0, 32'd1);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
      end
    join
    repeat (3) @(negedge clk);
    chk_gap = 1'b0;
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
